// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and state encoding for the tick rate controller
package clkdiv_pkg;
  localparam int PKG_CNT_W = 32;
  localparam int PKG_DEFAULT_DIV = 100;
  localparam int MIN_DIV = 1;
  typedef enum logic [1:0] {STOP = 2'b00, RUN = 2'b01, STEP = 2'b10, BAD = 2'b11} state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: period counter with terminal compare and registered terminal pulse
module tick_prescaler #(
  parameter int CNT_W = 32
) (
  input  logic             CLK_IN,
  input  logic             clr,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] div,
  output logic             hit,
  output logic             term
);
  logic [CNT_W-1:0] cnt;
  assign hit = cnt == div;
  always_ff @(posedge CLK_IN or posedge clr)
    if (clr) begin
      cnt  <= '0;
      term <= 1'b0;
    end else begin
      cnt  <= (clear || (en && hit)) ? '0 : en ? cnt + 1'b1 : cnt;
      term <= en && hit && !clear;
    end
endmodule

// File: rtl/tick_rate_ctrl.sv
// tick_rate_ctrl: run/stop/single-step tick generator with handshaked divide reload
module tick_rate_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = PKG_CNT_W,
  parameter int DEFAULT_DIV = PKG_DEFAULT_DIV,
  parameter int TCNT_W      = 16
) (
  input  logic              CLK_IN,
  input  logic              clr,
  input  logic              run,
  input  logic              step,
  input  logic              div_load_req,
  input  logic [CNT_W-1:0]  div_load_val,
  output logic              div_load_ack,
  output logic              tick,
  output logic              CLK_OUT,
  output logic [1:0]        state,
  output logic [TCNT_W-1:0] tick_count
);
  state_t st, nx;
  logic en, hit, fire, apply, ack_q, req_q, pend_valid;
  logic [CNT_W-1:0] div_cur, div_pend;
  always_ff @(posedge CLK_IN or posedge clr)
    if (clr) st <= STOP;
    else st <= nx;
  always_comb begin
    nx = STOP;
    case (st)
      STOP:    nx = run ? RUN : step ? STEP : STOP;
      RUN:     nx = run ? RUN : STOP;
      STEP:    nx = run ? RUN : hit ? STOP : STEP;
      default: nx = STOP;
    endcase
  end
  // dropping run in RUN clears the counter on that same edge, so the partial period never ticks
  always_comb begin
    state = st;
    en    = (st == RUN && run) || st == STEP;
  end
  assign fire  = en && hit;
  assign apply = pend_valid && (st == STOP || fire);
  tick_prescaler #(.CNT_W(CNT_W)) u_pre (
    .CLK_IN(CLK_IN),
    .clr(clr),
    .en(en),
    .clear(!en),
    .div(div_cur),
    .hit(hit),
    .term(tick)
  );
  // capture and apply are exclusive through pend_valid, so a same-edge capture waits a full period
  always_ff @(posedge CLK_IN or posedge clr)
    if (clr) begin
      req_q        <= 1'b0;
      pend_valid   <= 1'b0;
      div_pend     <= CNT_W'(DEFAULT_DIV);
      div_cur      <= CNT_W'(DEFAULT_DIV);
      ack_q        <= 1'b0;
      div_load_ack <= 1'b0;
      CLK_OUT      <= 1'b0;
      tick_count   <= '0;
    end else begin
      req_q <= div_load_req;
      if (div_load_req && !req_q && !pend_valid) begin
        div_pend   <= (div_load_val < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_load_val;
        pend_valid <= 1'b1;
      end else if (apply) pend_valid <= 1'b0;
      if (apply) div_cur <= div_pend;
      ack_q        <= apply;
      div_load_ack <= ack_q;
      if (fire) begin
        CLK_OUT    <= !CLK_OUT;
        tick_count <= tick_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_tick_rate_ctrl.sv
// tb_tick_rate_ctrl: scoreboard bench for tick timing, stepping, aborts, reloads and async reset
module tb_tick_rate_ctrl;
  logic        CLK_IN = 0, clr = 1, run = 0, step = 0, div_load_req = 0;
  logic [31:0] div_load_val = 0;
  logic        div_load_ack, tick, CLK_OUT;
  logic [1:0]  state;
  logic [15:0] tick_count;
  int checks = 0, errors = 0, cyc = 0, e_t, e_a, k, m;
  int tq[$], aq[$];
  logic exp_co = 0;

  tick_rate_ctrl dut (
    .CLK_IN(CLK_IN), .clr(clr), .run(run), .step(step),
    .div_load_req(div_load_req), .div_load_val(div_load_val),
    .div_load_ack(div_load_ack), .tick(tick), .CLK_OUT(CLK_OUT),
    .state(state), .tick_count(tick_count)
  );

  always #5 CLK_IN = ~CLK_IN;
  always @(posedge CLK_IN) cyc++;

  always @(negedge CLK_IN)
    if (clr) exp_co = 0;
    else begin
      if (tick) begin
        checks++;
        if (tq.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected at cycle %0d", cyc);
        end else begin
          e_t = tq.pop_front();
          if (cyc !== e_t) begin
            errors++;
            $display("FAIL tick_time got cycle %0d want %0d", cyc, e_t);
          end
        end
        exp_co = ~exp_co;
        checks++;
        if (CLK_OUT !== exp_co) begin
          errors++;
          $display("FAIL clk_out_toggle got %b want %b at cycle %0d", CLK_OUT, exp_co, cyc);
        end
      end
      if (div_load_ack) begin
        checks++;
        if (aq.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected at cycle %0d", cyc);
        end else begin
          e_a = aq.pop_front();
          if (cyc !== e_a) begin
            errors++;
            $display("FAIL ack_time got cycle %0d want %0d", cyc, e_a);
          end
        end
      end
    end

  task step_clk(input int n);
    repeat (n) begin
      @(posedge CLK_IN);
      #1;
    end
  endtask

  task test_reset;
    step_clk(3);
    clr = 0;
    step_clk(2);
    checks += 5;
    if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state); end
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
    if (CLK_OUT !== 1'b0) begin errors++; $display("FAIL reset_clk_out got %b want 0", CLK_OUT); end
    if (tick_count !== 16'd0) begin errors++; $display("FAIL reset_tick_count got %0d want 0", tick_count); end
    if (div_load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", div_load_ack); end
  endtask

  task test_run;
    k = cyc;
    run = 1;
    tq.push_back(k + 102); tq.push_back(k + 203); tq.push_back(k + 304);
    step_clk(2);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL run_state got %b want 01", state); end
    step_clk(302);
    checks++;
    if (tick_count !== 16'd3) begin errors++; $display("FAIL run_tick_count got %0d want 3", tick_count); end
    run = 0;
    step_clk(2);
    checks += 2;
    if (tq.size() !== 0) begin errors++; $display("FAIL run_ticks_missing got %0d pending want 0", tq.size()); end
    if (state !== 2'b00) begin errors++; $display("FAIL run_stop_state got %b want 00", state); end
  endtask

  task test_step;
    k = cyc;
    step = 1;
    tq.push_back(k + 102);
    step_clk(1);
    step = 0;
    step_clk(2);
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL step_state got %b want 10", state); end
    step_clk(100);
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL step_return got %b want 00", state); end
    step_clk(500);
    checks += 2;
    if (tq.size() !== 0) begin errors++; $display("FAIL step_tick_missing got %0d pending want 0", tq.size()); end
    if (tick_count !== 16'd4) begin errors++; $display("FAIL step_tick_count got %0d want 4", tick_count); end
  endtask

  task test_abort;
    k = cyc;
    run = 1;
    step_clk(41);
    run = 0;
    step_clk(4);
    checks += 2;
    if (state !== 2'b00) begin errors++; $display("FAIL abort_state got %b want 00", state); end
    if (tick_count !== 16'd4) begin errors++; $display("FAIL abort_tick_count got %0d want 4", tick_count); end
    step_clk(20);
    k = cyc;
    run = 1;
    tq.push_back(k + 102);
    step_clk(102);
    run = 0;
    step_clk(2);
    checks += 2;
    if (tq.size() !== 0) begin errors++; $display("FAIL abort_reentry_tick got %0d pending want 0", tq.size()); end
    if (tick_count !== 16'd5) begin errors++; $display("FAIL abort_final_count got %0d want 5", tick_count); end
  endtask

  task test_clr_pending;
    k = cyc;
    run = 1;
    step_clk(31);
    div_load_req = 1;
    div_load_val = 5;
    step_clk(30);
    checks += 2;
    if (tick_count !== 16'd5) begin errors++; $display("FAIL preclr_count got %0d want 5", tick_count); end
    if (CLK_OUT !== 1'b1) begin errors++; $display("FAIL preclr_clk_out got %b want 1", CLK_OUT); end
    clr = 1;
    #1;
    checks += 5;
    if (state !== 2'b00) begin errors++; $display("FAIL clr_state got %b want 00", state); end
    if (tick !== 1'b0) begin errors++; $display("FAIL clr_tick got %b want 0", tick); end
    if (CLK_OUT !== 1'b0) begin errors++; $display("FAIL clr_clk_out got %b want 0", CLK_OUT); end
    if (tick_count !== 16'd0) begin errors++; $display("FAIL clr_tick_count got %0d want 0", tick_count); end
    if (div_load_ack !== 1'b0) begin errors++; $display("FAIL clr_ack got %b want 0", div_load_ack); end
    div_load_req = 0;
    run = 0;
    step_clk(2);
    clr = 0;
    step_clk(200);
    k = cyc;
    run = 1;
    tq.push_back(k + 102); tq.push_back(k + 203);
    step_clk(203);
    run = 0;
    step_clk(2);
    checks += 3;
    if (tq.size() !== 0) begin errors++; $display("FAIL clr_default_div got %0d pending want 0", tq.size()); end
    if (aq.size() !== 0) begin errors++; $display("FAIL clr_ack_queue got %0d pending want 0", aq.size()); end
    if (tick_count !== 16'd2) begin errors++; $display("FAIL clr_post_count got %0d want 2", tick_count); end
  endtask

  task test_load_run;
    k = cyc;
    run = 1;
    tq.push_back(k + 102); tq.push_back(k + 112); tq.push_back(k + 122); tq.push_back(k + 132);
    aq.push_back(k + 103);
    step_clk(51);
    div_load_req = 1;
    div_load_val = 9;
    step_clk(5);
    div_load_req = 0;
    step_clk(76);
    run = 0;
    step_clk(2);
    checks += 3;
    if (tq.size() !== 0) begin errors++; $display("FAIL load_run_ticks got %0d pending want 0", tq.size()); end
    if (aq.size() !== 0) begin errors++; $display("FAIL load_run_ack got %0d pending want 0", aq.size()); end
    if (state !== 2'b00) begin errors++; $display("FAIL load_run_state got %b want 00", state); end
  endtask

  task test_load_zero;
    k = cyc;
    div_load_req = 1;
    div_load_val = 0;
    aq.push_back(k + 3);
    step_clk(4);
    div_load_req = 0;
    checks++;
    if (aq.size() !== 0) begin errors++; $display("FAIL zero_ack got %0d pending want 0", aq.size()); end
    m = cyc;
    run = 1;
    tq.push_back(m + 3); tq.push_back(m + 5); tq.push_back(m + 7); tq.push_back(m + 9);
    step_clk(9);
    run = 0;
    step_clk(2);
    checks++;
    if (tq.size() !== 0) begin errors++; $display("FAIL zero_period got %0d pending want 0", tq.size()); end
  endtask

  initial begin
    test_reset;
    test_run;
    test_step;
    test_abort;
    test_clr_pending;
    test_load_run;
    test_load_zero;
    step_clk(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tick_rate_ctrl.md
Name: tick_rate_ctrl

Overview:
- Run/stop/single-step controller for the system divider.
- Produces a 1-cycle `tick` enable and a divided square wave `CLK_OUT` from `CLK_IN`.
- Accepts divide-ratio reprogramming through a req/ack handshake; the new ratio is applied only at a period boundary, so no runt period occurs.
- Sits between the top-level control logic (game speed, pause, debug step) and every block that advances on the divided rate.

Parameters:
- CNT_W, 32, width of the prescaler counter and divide register.
- DEFAULT_DIV, 100, divide value after reset; period = div + 1 cycles.
- TCNT_W, 16, width of the tick counter.

Ports:
- CLK_IN  input  1  system clock, all logic on rising edge.
- clr  input  1  asynchronous, active-high reset.
- run  input  1  level: 1 = free-running ticks, 0 = stop.
- step  input  1  1-cycle pulse: issue exactly one tick while stopped.
- div_load_req  input  1  request to load a new divide value; rising edge captured.
- div_load_val  input  CNT_W  new divide value, sampled on the `div_load_req` rising edge.
- div_load_ack  output  1  1-cycle pulse, one cycle after the new value takes effect.
- tick  output  1  1-cycle enable pulse, once per period.
- CLK_OUT  output  1  toggles on every tick (50% duty, period 2*(div+1)).
- state  output  2  current FSM state.
- tick_count  output  TCNT_W  ticks issued since reset; wraps.

Behaviour:
- Reset (`clr` high, async):
  - cnt=0, CLK_OUT=0, tick=0, div_load_ack=0, state=STOP.
  - div_cur=DEFAULT_DIV, pend_valid=0, tick_count=0, req_q=0.
  - `clr` mid-period aborts the period, and any pending load is discarded with no ack.
- States: STOP=2'b00, RUN=2'b01, STEP=2'b10. Encoding 2'b11 is illegal and recovers to STOP.
- STOP:
  - cnt held at 0, no ticks, CLK_OUT holds its value.
  - run=1 goes to RUN; run=0 with step=1 goes to STEP.
  - run=1 and step=1 in the same cycle goes to RUN.
- RUN: cnt increments each cycle. On an edge where cnt==div_cur:
  - cnt<=0, tick<=1, CLK_OUT<=~CLK_OUT, tick_count<=tick_count+1.
  - run=0 goes to STOP next edge, cnt cleared, and the partial period is discarded.
  - step is ignored.
- STEP:
  - Counts exactly as RUN. At terminal count it issues one tick and returns to STOP.
  - run=1 during STEP goes to RUN without restarting cnt.
- Tick timing:
  - First tick is asserted in the cycle after the (div_cur+1)th edge following entry to RUN/STEP.
  - Subsequent ticks follow every div_cur+1 cycles.
  - tick never stays high for 2 consecutive cycles unless div_cur=1 at maximum rate (period 2, so this cannot occur).
- Load handshake:
  - A rising edge on `div_load_req` (req_q registered) captures div_load_val into div_pend and sets pend_valid.
  - A value of 0 is clamped to 1.
  - Edges while pend_valid=1 are ignored; the requester must wait for ack.
- Load apply:
  - In STOP: div_cur<=div_pend on the edge after capture.
  - In RUN/STEP: applied on the terminal-count edge. The current period finishes on the old value and the next period uses the new one.
  - div_load_ack pulses for 1 cycle after the apply edge, and pend_valid clears.
  - Capture and terminal count on the same edge: the value is captured only and applied at the next terminal count.
- `tick_count` wraps from 2^TCNT_W-1 to 0 with no flag.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package `clkdiv_pkg` holds:
  - the state encoding constants (STOP, RUN, STEP);
  - DEFAULT_DIV;
  - MIN_DIV=1;
  - the CNT_W default.
- Sub-module `tick_prescaler`:
  - contains cnt, terminal compare, clear and enable inputs, and a registered terminal pulse output.
  - The FSM, load handshake, CLK_OUT toggle and tick_count stay in `tick_rate_ctrl`.

Test Plan:
- Reset, then run=1 with DEFAULT_DIV=100:
  - first tick 101 cycles after state=RUN, then every 101 cycles;
  - CLK_OUT toggles at each tick;
  - tick_count=3 after three ticks.
- In STOP, pulse step once:
  - exactly one tick, 101 cycles later;
  - state returns to STOP;
  - no further ticks over 500 cycles.
- In RUN with div=100, raise div_load_req with val=9 at cnt=50:
  - the current period still completes at 101 cycles;
  - ack pulses the cycle after that tick;
  - following periods are 10 cycles.
- In STOP, load val=0:
  - ack on the second cycle after the req edge;
  - with run=1 the period is 2 cycles (clamped to 1) and CLK_OUT has period 4.
- During RUN, drop run at cnt=40, then raise it again:
  - no tick is issued for the aborted period;
  - next tick 101 cycles after re-entry.
- Assert clr mid-period with a load pending:
  - all outputs go to reset values asynchronously;
  - no ack appears;
  - div_cur=100 after release.
